// File: rtl/vga_pkg.sv
// Shared timing presets, RGB565 colours, pattern-mode encodings and the
// sideband record carried through the fetch-latency delay line.
package vga_pkg;

    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;

    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BACK   = 88;
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FRONT  = 40;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BACK   = 23;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FRONT  = 1;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_WHITE = 2'd3;

    // Everything the output stage needs about a pixel, captured at request time.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [2:0] bar;
        logic       chk;
        logic       fs;
    } side_t;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipe with async active-high reset; DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign dout_o = din_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: requests pixels PIX_LAT cycles early and registers
// rgb/hsync/vsync/de so every mode reaches the pins PIX_LAT+1 cycles after its coordinates.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BACK   = VGA640_H_BACK,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FRONT  = VGA640_H_FRONT,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BACK   = VGA640_V_BACK,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FRONT  = VGA640_V_FRONT,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 1,
    parameter int CNT_W    = 10
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [15:0]      pic_data,
    output logic             pic_req,
    output logic [CNT_W-1:0] pic_x,
    output logic [CNT_W-1:0] pic_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [15:0]      rgb_data,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int H_ACT1  = H_ACT0 + H_ACTIVE;
    localparam int V_ACT0  = V_SYNC + V_BACK;
    localparam int V_ACT1  = V_ACT0 + V_ACTIVE;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] x_off, y_off, bar_full;
    logic             h_act, v_act, act, frame_top;
    side_t            side_raw, side_dly;
    logic [1:0]       mode_lat_q;
    logic [15:0]      pix_sel, rgb_q;
    logic             hsync_q, vsync_q, de_q, frame_start_q;
    logic [7:0]       frame_cnt_q;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    assign frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);

    // The pattern mode only changes on a frame boundary so a frame is never mixed.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            mode_lat_q <= MODE_EXT;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (frame_top) mode_lat_q <= mode;
        end
    end

    assign x_off    = h_cnt_q - CNT_W'(H_ACT0);
    assign y_off    = v_cnt_q - CNT_W'(V_ACT0);
    assign h_act    = (32'(h_cnt_q) >= 32'(H_ACT0)) && (32'(h_cnt_q) < 32'(H_ACT1));
    assign v_act    = (32'(v_cnt_q) >= 32'(V_ACT0)) && (32'(v_cnt_q) < 32'(V_ACT1));
    assign act      = h_act && v_act;
    assign bar_full = x_off / CNT_W'(BAR_W);

    assign pic_req = act;
    assign pic_x   = act ? x_off : '0;
    assign pic_y   = act ? y_off : '0;

    always_comb begin
        side_raw     = '0;
        side_raw.hs  = 32'(h_cnt_q) < 32'(H_SYNC);
        side_raw.vs  = 32'(v_cnt_q) < 32'(V_SYNC);
        side_raw.act = act;
        side_raw.bar = (bar_full > CNT_W'(7)) ? 3'd7 : bar_full[2:0];
        side_raw.chk = x_off[5] ^ y_off[5];
        side_raw.fs  = frame_top;
    end

    vga_delay_line #(
        .WIDTH ($bits(side_t)),
        .DEPTH (PIX_LAT)
    ) u_side_dly (
        .clk_i  (vga_clk),
        .rst_i  (rst),
        .din_i  (side_raw),
        .dout_o (side_dly)
    );

    always_comb begin
        case (mode_lat_q)
            MODE_EXT:   pix_sel = pic_data;
            MODE_BARS:  pix_sel = bar_colour(side_dly.bar);
            MODE_CHECK: pix_sel = side_dly.chk ? RGB_WHITE : RGB_BLACK;
            default:    pix_sel = RGB_WHITE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hsync_q       <= side_dly.hs ? HS_POL : ~HS_POL;
            vsync_q       <= side_dly.vs ? VS_POL : ~VS_POL;
            de_q          <= side_dly.act;
            rgb_q         <= side_dly.act ? pix_sel : RGB_BLACK;
            frame_start_q <= side_dly.fs;
            if (side_dly.fs) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb_data    = rgb_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
